// File: rtl/ir_pkg.sv
// rtl/ir_pkg.sv - shared frame layout, address-mode constants and FSM states for IR frame handling
package ir_pkg;

    localparam int ADDR_LSB = 0;
    localparam int ACHK_LSB = 8;
    localparam int CMD_LSB  = 16;
    localparam int NCMD_LSB = 24;

    localparam bit ADDR_MODE_SAMSUNG = 1'b0;
    localparam bit ADDR_MODE_NEC     = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CAPTURE,
        ST_CHECK,
        ST_EMIT,
        ST_WAIT_REL
    } ir_state_e;

    function automatic logic [7:0] frame_byte(input logic [31:0] frame, input int lsb);
        return frame[lsb +: 8];
    endfunction

endpackage

// File: rtl/ir_frame_checker_if.sv
// rtl/ir_frame_checker_if.sv - decoder-side frame handshake and key-side valid/ready output
interface ir_frame_checker_if;

    logic        dec_ready;
    logic [31:0] dec_cmd;
    logic        dec_ack;
    logic        key_valid;
    logic        key_ready;
    logic [7:0]  key_code;
    logic [7:0]  key_addr;
    logic        key_repeat;

    modport master (
        output dec_ready, dec_cmd, key_ready,
        input  dec_ack, key_valid, key_code, key_addr, key_repeat
    );

    modport slave (
        input  dec_ready, dec_cmd, key_ready,
        output dec_ack, key_valid, key_code, key_addr, key_repeat
    );

endinterface

// File: rtl/ir_hold_timer.sv
// rtl/ir_hold_timer.sv - loadable down-counter; expired is high whenever the count sits at zero
module ir_hold_timer #(
    parameter int HOLD_CYC = 3_000_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic load,
    output logic expired
);

    localparam int W = $clog2(HOLD_CYC + 1);
    localparam logic [W-1:0] RELOAD = W'(HOLD_CYC);

    logic [W-1:0] count;

    // A load takes priority over the decrement so a refresh always restarts the full window.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (load) begin
            count <= RELOAD;
        end else if (count != '0) begin
            count <= count - 1'b1;
        end
    end

    assign expired = (count == '0);

endmodule

// File: rtl/ir_frame_checker.sv
// rtl/ir_frame_checker.sv - validates raw IR frames, filters by address, flags auto-repeat and
// presents key codes on a one-entry valid/ready slot
module ir_frame_checker
    import ir_pkg::*;
#(
    parameter bit       ADDR_MODE = ADDR_MODE_SAMSUNG,
    parameter bit       ADDR_FILT = 1'b1,
    parameter logic [7:0] EXP_ADDR = 8'h07,
    parameter int       HOLD_CYC  = 3_000_000
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               enable,
    ir_frame_checker_if.slave  bus,
    output logic               key_held,
    output logic [7:0]         err_cnt,
    output logic [7:0]         drop_cnt
);

    ir_state_e   state;
    ir_state_e   state_nxt;

    logic [31:0] frame;
    logic        frame_ok;
    logic [7:0]  last_code;

    logic        key_valid_q;
    logic [7:0]  key_code_q;
    logic [7:0]  key_addr_q;
    logic        key_repeat_q;

    logic [7:0]  f_addr;
    logic [7:0]  f_achk;
    logic [7:0]  f_cmd;
    logic [7:0]  f_ncmd;
    logic        cmd_ok;
    logic        achk_ok;
    logic        filt_ok;

    logic        emit;
    logic        emit_good;
    logic        emit_err;
    logic        slot_busy;
    logic        hold_active;
    logic        timer_expired;

    assign f_addr = frame_byte(frame, ADDR_LSB);
    assign f_achk = frame_byte(frame, ACHK_LSB);
    assign f_cmd  = frame_byte(frame, CMD_LSB);
    assign f_ncmd = frame_byte(frame, NCMD_LSB);

    assign cmd_ok  = ((f_cmd ^ f_ncmd) == 8'hFF);
    assign achk_ok = (ADDR_MODE == ADDR_MODE_NEC) ? ((f_addr ^ f_achk) == 8'hFF)
                                                  : (f_addr == f_achk);
    assign filt_ok = !ADDR_FILT || (f_addr == EXP_ADDR);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:     if (bus.dec_ready) state_nxt = ST_CAPTURE;
            ST_CAPTURE:  state_nxt = ST_CHECK;
            ST_CHECK:    state_nxt = ST_EMIT;
            ST_EMIT:     state_nxt = ST_WAIT_REL;
            ST_WAIT_REL: if (!bus.dec_ready) state_nxt = ST_IDLE;
            default:     state_nxt = ST_IDLE;
        endcase
    end

    assign emit      = (state == ST_EMIT) && enable;
    assign emit_good = emit && frame_ok;
    assign emit_err  = emit && !frame_ok;
    // A handshake in the same cycle frees the slot, so a simultaneous load is not a drop.
    assign slot_busy = key_valid_q && !bus.key_ready;

    // last_ok and key_held are set by the same reload and cleared by the same expiry,
    // so both are represented by the timer's running state.
    assign hold_active = !timer_expired;

    ir_hold_timer #(
        .HOLD_CYC (HOLD_CYC)
    ) u_hold_timer (
        .clk     (clk),
        .rst_n   (rst_n),
        .load    (emit_good),
        .expired (timer_expired)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame        <= '0;
            frame_ok     <= 1'b0;
            last_code    <= 8'h00;
            key_valid_q  <= 1'b0;
            key_code_q   <= 8'h00;
            key_addr_q   <= 8'h00;
            key_repeat_q <= 1'b0;
            err_cnt      <= 8'h00;
            drop_cnt     <= 8'h00;
        end else begin
            if (state == ST_CAPTURE) begin
                frame <= bus.dec_cmd;
            end
            if (state == ST_CHECK) begin
                frame_ok <= cmd_ok && achk_ok && filt_ok;
            end
            if (key_valid_q && bus.key_ready) begin
                key_valid_q <= 1'b0;
            end
            if (emit_err && (err_cnt != 8'hFF)) begin
                err_cnt <= err_cnt + 8'd1;
            end
            if (emit_good) begin
                last_code <= f_cmd;
                if (slot_busy) begin
                    if (drop_cnt != 8'hFF) begin
                        drop_cnt <= drop_cnt + 8'd1;
                    end
                end else begin
                    key_valid_q  <= 1'b1;
                    key_code_q   <= f_cmd;
                    key_addr_q   <= f_addr;
                    key_repeat_q <= hold_active && (f_cmd == last_code);
                end
            end
        end
    end

    assign bus.dec_ack    = (state == ST_CAPTURE);
    assign bus.key_valid  = key_valid_q;
    assign bus.key_code   = key_code_q;
    assign bus.key_addr   = key_addr_q;
    assign bus.key_repeat = key_repeat_q;
    assign key_held       = hold_active;

endmodule

// File: tb/tb_ir_frame_checker.sv
// tb/tb_ir_frame_checker.sv - scoreboard bench for ir_frame_checker with a filtered and an unfiltered instance
module tb_ir_frame_checker;

    logic       clk;
    logic       rst_n;
    logic       enable;
    logic       key_held;
    logic [7:0] err_cnt;
    logic [7:0] drop_cnt;
    logic       key_held2;
    logic [7:0] err_cnt2;
    logic [7:0] drop_cnt2;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct packed {
        logic [7:0] code;
        logic [7:0] addr;
        logic       rpt;
    } exp_t;

    exp_t exp_q[$];

    ir_frame_checker_if bus ();
    ir_frame_checker_if bus2 ();

    assign bus2.dec_ready = bus.dec_ready;
    assign bus2.dec_cmd   = bus.dec_cmd;
    assign bus2.key_ready = 1'b1;

    ir_frame_checker #(
        .ADDR_MODE (1'b0),
        .ADDR_FILT (1'b1),
        .EXP_ADDR  (8'h07),
        .HOLD_CYC  (100)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .enable   (enable),
        .bus      (bus.slave),
        .key_held (key_held),
        .err_cnt  (err_cnt),
        .drop_cnt (drop_cnt)
    );

    ir_frame_checker #(
        .ADDR_MODE (1'b0),
        .ADDR_FILT (1'b0),
        .EXP_ADDR  (8'h07),
        .HOLD_CYC  (100)
    ) dut_nofilt (
        .clk      (clk),
        .rst_n    (rst_n),
        .enable   (enable),
        .bus      (bus2.slave),
        .key_held (key_held2),
        .err_cnt  (err_cnt2),
        .drop_cnt (drop_cnt2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Key-side scoreboard: samples late in the low phase, after the drivers have settled.
    always begin
        exp_t got;
        exp_t e;
        @(negedge clk);
        #3;
        if (rst_n && bus.key_valid && bus.key_ready) begin
            got = '{code: bus.key_code, addr: bus.key_addr, rpt: bus.key_repeat};
            n_checks++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL sb_unexpected: got code=%h addr=%h rpt=%b, required no key", got.code, got.addr, got.rpt);
            end else begin
                e = exp_q.pop_front();
                if (got !== e) begin
                    n_fail++;
                    $display("FAIL sb_key: got code=%h addr=%h rpt=%b, required code=%h addr=%h rpt=%b",
                             got.code, got.addr, got.rpt, e.code, e.addr, e.rpt);
                end
            end
        end
    end

    task automatic drive_frame(input logic [31:0] cmd, input int hold_cyc, output int acks);
        acks = 0;
        bus.dec_cmd   = cmd;
        bus.dec_ready = 1'b1;
        for (int i = 0; i < 8 + hold_cyc; i++) begin
            @(negedge clk);
            if (bus.dec_ack === 1'b1) acks++;
            if (acks > 0 && i >= hold_cyc) bus.dec_ready = 1'b0;
        end
        bus.dec_ready = 1'b0;
    endtask

    task automatic test_reset;
        repeat (2) @(negedge clk);
        n_checks++;
        if ({bus.dec_ack, bus.key_valid, bus.key_code, bus.key_addr, bus.key_repeat, key_held, err_cnt, drop_cnt} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: got ack=%b kv=%b code=%h addr=%h rpt=%b held=%b err=%0d drop=%0d, required all 0",
                     bus.dec_ack, bus.key_valid, bus.key_code, bus.key_addr, bus.key_repeat, key_held, err_cnt, drop_cnt);
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_basic;
        bus.key_ready = 1'b0;
        bus.dec_cmd   = 32'hFD02_0707;
        bus.dec_ready = 1'b1;
        @(negedge clk);
        n_checks++;
        if (bus.dec_ack !== 1'b1) begin n_fail++; $display("FAIL basic_ack: got %b, required 1", bus.dec_ack); end
        bus.dec_ready = 1'b0;
        @(negedge clk);
        n_checks++;
        if (bus.dec_ack !== 1'b0) begin n_fail++; $display("FAIL basic_ack_pulse: got %b, required 0", bus.dec_ack); end
        @(negedge clk);
        n_checks++;
        if (bus.key_valid !== 1'b0) begin n_fail++; $display("FAIL basic_early_valid: got %b, required 0", bus.key_valid); end
        @(negedge clk);
        n_checks++;
        if ({bus.key_valid, bus.key_code, bus.key_addr, bus.key_repeat, key_held} !== {1'b1, 8'h02, 8'h07, 1'b0, 1'b1}) begin
            n_fail++;
            $display("FAIL basic_key: got kv=%b code=%h addr=%h rpt=%b held=%b, required kv=1 code=02 addr=07 rpt=0 held=1",
                     bus.key_valid, bus.key_code, bus.key_addr, bus.key_repeat, key_held);
        end
        exp_q.push_back('{code: 8'h02, addr: 8'h07, rpt: 1'b0});
        bus.key_ready = 1'b1;
    endtask

    task automatic test_repeat;
        repeat (46) @(negedge clk);
        exp_q.push_back('{code: 8'h02, addr: 8'h07, rpt: 1'b1});
        bus.dec_cmd   = 32'hFD02_0707;
        bus.dec_ready = 1'b1;
        @(negedge clk);
        n_checks++;
        if (bus.dec_ack !== 1'b1) begin n_fail++; $display("FAIL repeat_ack: got %b, required 1", bus.dec_ack); end
        bus.dec_ready = 1'b0;
        @(negedge clk);
        n_checks++;
        if (key_held !== 1'b1) begin n_fail++; $display("FAIL repeat_held_on: got %b, required 1", key_held); end
        repeat (101) @(negedge clk);
        n_checks++;
        if (key_held !== 1'b1) begin n_fail++; $display("FAIL hold_before_expiry: got %b, required 1", key_held); end
        @(negedge clk);
        n_checks++;
        if (key_held !== 1'b0) begin n_fail++; $display("FAIL hold_expiry: got %b, required 0", key_held); end
    endtask

    task automatic test_bad_cmd;
        int acks;
        exp_q.push_back('{code: 8'h02, addr: 8'h07, rpt: 1'b0});
        drive_frame(32'hFD02_0707, 0, acks);
        drive_frame(32'hFC02_0707, 0, acks);
        n_checks++;
        if (acks != 1) begin n_fail++; $display("FAIL badcmd_acks: got %0d, required 1", acks); end
        n_checks++;
        if ({err_cnt, key_held, bus.key_valid} !== {8'd1, 1'b1, 1'b0}) begin
            n_fail++;
            $display("FAIL badcmd_state: got err=%0d held=%b kv=%b, required err=1 held=1 kv=0", err_cnt, key_held, bus.key_valid);
        end
    endtask

    task automatic test_addr_filter;
        bus.dec_cmd   = 32'hFD02_0909;
        bus.dec_ready = 1'b1;
        @(negedge clk);
        n_checks++;
        if (bus.dec_ack !== 1'b1) begin n_fail++; $display("FAIL addr_ack: got %b, required 1", bus.dec_ack); end
        bus.dec_ready = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++;
        if ({bus2.key_valid, bus2.key_code, bus2.key_addr} !== {1'b1, 8'h02, 8'h09}) begin
            n_fail++;
            $display("FAIL nofilt_key: got kv=%b code=%h addr=%h, required kv=1 code=02 addr=09", bus2.key_valid, bus2.key_code, bus2.key_addr);
        end
        n_checks++;
        if (bus.key_valid !== 1'b0) begin n_fail++; $display("FAIL addr_filtered_valid: got %b, required 0", bus.key_valid); end
        repeat (4) @(negedge clk);
        n_checks++;
        if ({err_cnt, err_cnt2, drop_cnt2, key_held2} !== {8'd2, 8'd1, 8'd0, 1'b1}) begin
            n_fail++;
            $display("FAIL addr_counts: got err=%0d err2=%0d drop2=%0d held2=%b, required err=2 err2=1 drop2=0 held2=1",
                     err_cnt, err_cnt2, drop_cnt2, key_held2);
        end
    endtask

    task automatic test_backpressure;
        int acks;
        bus.key_ready = 1'b0;
        exp_q.push_back('{code: 8'h05, addr: 8'h07, rpt: 1'b0});
        drive_frame(32'hFA05_0707, 0, acks);
        n_checks++;
        if ({bus.key_valid, bus.key_code} !== {1'b1, 8'h05}) begin
            n_fail++; $display("FAIL bp_first: got kv=%b code=%h, required kv=1 code=05", bus.key_valid, bus.key_code);
        end
        drive_frame(32'hF708_0707, 0, acks);
        n_checks++;
        if ({bus.key_valid, bus.key_code, bus.key_addr, drop_cnt} !== {1'b1, 8'h05, 8'h07, 8'd1}) begin
            n_fail++;
            $display("FAIL bp_hold: got kv=%b code=%h addr=%h drop=%0d, required kv=1 code=05 addr=07 drop=1",
                     bus.key_valid, bus.key_code, bus.key_addr, drop_cnt);
        end
        bus.key_ready = 1'b1;
        @(negedge clk);
        n_checks++;
        if (bus.key_valid !== 1'b0) begin n_fail++; $display("FAIL bp_release: got kv=%b, required 0", bus.key_valid); end
        n_checks++;
        if (exp_q.size() != 0) begin n_fail++; $display("FAIL bp_consumed: got %0d pending, required 0", exp_q.size()); end
    endtask

    task automatic test_disable;
        int acks;
        enable = 1'b0;
        drive_frame(32'hFD02_0707, 0, acks);
        n_checks++;
        if (acks != 1) begin n_fail++; $display("FAIL disable_ack: got %0d, required 1", acks); end
        drive_frame(32'hFC02_0707, 0, acks);
        n_checks++;
        if ({bus.key_valid, err_cnt, drop_cnt} !== {1'b0, 8'd2, 8'd1}) begin
            n_fail++;
            $display("FAIL disable_state: got kv=%b err=%0d drop=%0d, required kv=0 err=2 drop=1", bus.key_valid, err_cnt, drop_cnt);
        end
        enable = 1'b1;
    endtask

    task automatic test_back_to_back;
        int acks;
        exp_q.push_back('{code: 8'h02, addr: 8'h07, rpt: 1'b0});
        drive_frame(32'hFD02_0707, 20, acks);
        n_checks++;
        if (acks != 1) begin n_fail++; $display("FAIL long_ready_acks: got %0d, required 1", acks); end
        n_checks++;
        if (exp_q.size() != 0) begin n_fail++; $display("FAIL long_ready_keys: got %0d pending, required 0", exp_q.size()); end
    endtask

    task automatic test_reset_mid;
        bus.dec_cmd   = 32'hFD02_0707;
        bus.dec_ready = 1'b1;
        @(negedge clk);
        bus.dec_ready = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({bus.dec_ack, bus.key_valid, bus.key_code, key_held, err_cnt, drop_cnt} !== '0) begin
            n_fail++;
            $display("FAIL midreset_outputs: got ack=%b kv=%b code=%h held=%b err=%0d drop=%0d, required all 0",
                     bus.dec_ack, bus.key_valid, bus.key_code, key_held, err_cnt, drop_cnt);
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (6) @(negedge clk);
        n_checks++;
        if (bus.key_valid !== 1'b0) begin n_fail++; $display("FAIL midreset_no_key: got kv=%b, required 0", bus.key_valid); end
    endtask

    initial begin
        rst_n         = 1'b0;
        enable        = 1'b1;
        bus.dec_ready = 1'b0;
        bus.dec_cmd   = '0;
        bus.key_ready = 1'b0;
        test_reset;
        test_basic;
        test_repeat;
        test_bad_cmd;
        test_addr_filter;
        test_backpressure;
        test_disable;
        test_back_to_back;
        test_reset_mid;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
